instr_loader: RTL and testbench
===============================

INSTR_LOADER -- requirements
Module: instr_loader

Interface
REQ-001 SHALL have port Clk, input, 1: sole clock, all state updates on rising edge.
REQ-002 SHALL have port Rst, input, 1: synchronous, active-high reset.
REQ-003 SHALL have port ByteValid, input, 1: source offers ByteData this cycle.
REQ-004 SHALL have port ByteData, input, 8: loader stream byte.
REQ-005 SHALL have port ByteReady, output, 1: loader accepts a byte; a transfer occurs when ByteValid and ByteReady are both 1.
REQ-006 SHALL have port MemWriteEn, output, 1: one-cycle instruction-memory write strobe.
REQ-007 SHALL have port MemAddr, output, 12: instruction word address.
REQ-008 SHALL have port MemWriteData, output, 16: instruction word to write.
REQ-009 SHALL have port CpuRst, output, 1: reset to controller and datapath; 1 holds the CPU in reset.
REQ-010 SHALL have port Done, output, 1: last load passed checksum and the CPU is running.
REQ-011 SHALL have port Error, output, 1: last load failed.

Function
REQ-012 Frame format SHALL be: header 0xA5, count high byte, count low byte, count words each sent high byte first, then one checksum byte.
REQ-013 Checksum SHALL be the XOR of every byte after the header, excluding the checksum byte itself.
REQ-014 States SHALL be IDLE, CNT_HI, CNT_LO, DATA_HI, DATA_LO, WRITE, CHECK, RUN and ERR.
REQ-015 In IDLE, RUN and ERR, an accepted 0xA5 SHALL go to CNT_HI, clear the XOR accumulator, set MemAddr=0, set CpuRst=1 and clear Done and Error on the next cycle; any other byte SHALL be consumed and ignored.
REQ-016 In CNT_LO, count >4096 SHALL go to ERR; count=0 SHALL go to CHECK; any other count SHALL go to DATA_HI.
REQ-017 After the low byte is accepted in DATA_LO, the FSM SHALL enter WRITE for exactly one cycle.
REQ-018 In WRITE, MemWriteEn SHALL be 1 with MemAddr and MemWriteData stable, and ByteReady SHALL be 0.
REQ-019 On leaving WRITE, MemAddr SHALL increment and the remaining count SHALL decrement; the FSM SHALL go to CHECK if the remaining count is 0, otherwise to DATA_HI.
REQ-020 In CHECK, an accepted byte equal to the accumulator SHALL go to RUN, with CpuRst=0 and Done=1 from the next cycle; a mismatch SHALL go to ERR with Error=1 and CpuRst=1.
REQ-021 ByteReady SHALL be 1 in every state except WRITE, and SHALL be 0 while Rst=1.
REQ-022 While ByteValid=0, the FSM SHALL hold its state, and MemWriteEn SHALL never assert outside WRITE.
REQ-023 MemAddr SHALL never wrap within a frame; the count limit of REQ-016 guarantees this.
REQ-024 Words already written before an ERR SHALL remain in memory; the CPU SHALL stay in reset until a later frame passes its checksum.

Reset
REQ-025 On a Clk edge with Rst=1, the block SHALL enter IDLE with CpuRst=1, MemWriteEn=0, MemAddr=0, MemWriteData=0, Done=0, Error=0, and the accumulator and count at 0.
REQ-026 Rst mid-frame SHALL abandon the frame with no further writes and return to IDLE.
REQ-027 Rst while in RUN SHALL reassert CpuRst on the same edge.

Structure
REQ-028 The shared package SHALL hold HDR_BYTE=8'hA5, IMEM_ADDR_W=12, IMEM_DEPTH=4096 and the loader state encoding.
REQ-029 A single sub-module, loader_xor_acc (8-bit XOR accumulator with clear and enable), is natural; all other logic SHALL reside in instr_loader.

Verification
REQ-030 Good frame: stream A5 00 02 12 34 AB CD 42 -> writes addr0=0x1234 and addr1=0xABCD; each MemWriteEn pulse is one cycle; then CpuRst=0, Done=1, Error=0.
REQ-031 Bad checksum: same frame with checksum 43 -> both writes occur, then Error=1, CpuRst=1, Done=0.
REQ-032 Limits: stream A5 10 01 (count 4097) -> ERR, zero writes. Stream A5 00 00 00 -> zero writes, then Done=1 and CpuRst=0.
REQ-033 Backpressure: ByteValid held high continuously through the good frame -> ByteReady=0 in each WRITE cycle, no byte lost or duplicated, same writes as REQ-030.
REQ-034 Rst after A5 00 02 12 -> no writes, all outputs at reset values; the REQ-030 frame sent afterwards completes normally.
REQ-035 Reload from RUN: 0xA5 after Done -> CpuRst=1 and Done=0 on the next cycle; a new frame loads from addr0.

Source files
------------

// File: rtl/instr_loader_pkg.sv
// Shared constants and state encoding for the instruction-memory boot loader.
package instr_loader_pkg;

  localparam logic [7:0] HDR_BYTE    = 8'hA5;
  localparam int         IMEM_ADDR_W = 12;
  localparam int         IMEM_DEPTH  = 4096;
  localparam int         COUNT_W     = IMEM_ADDR_W + 1;

  typedef enum logic [3:0] {
    IDLE,
    CNT_HI,
    CNT_LO,
    DATA_HI,
    DATA_LO,
    WRITE,
    CHECK,
    RUN,
    ERR
  } loader_state_e;

endpackage

// File: rtl/instr_loader_xor_acc.sv
// Running XOR of frame bytes, cleared at each new header.
module loader_xor_acc (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       clear_i,
  input  logic       en_i,
  input  logic [7:0] data_i,
  output logic [7:0] acc_o
);

  logic [7:0] acc_q;

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      acc_q <= '0;
    end else if (en_i) begin
      acc_q <= acc_q ^ data_i;
    end
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/instr_loader.sv
// Byte-stream loader: parses framed instruction words into instruction memory
// and releases the CPU from reset once the frame checksum matches.
module instr_loader
  import instr_loader_pkg::*;
(
  input  logic                   Clk,
  input  logic                   Rst,
  input  logic                   ByteValid,
  input  logic [7:0]             ByteData,
  output logic                   ByteReady,
  output logic                   MemWriteEn,
  output logic [IMEM_ADDR_W-1:0] MemAddr,
  output logic [15:0]            MemWriteData,
  output logic                   CpuRst,
  output logic                   Done,
  output logic                   Error
);

  localparam logic [15:0] MAX_COUNT = 16'(IMEM_DEPTH);

  loader_state_e          state_q;
  logic [7:0]             hiByte_q;
  logic [COUNT_W-1:0]     count_q;
  logic [IMEM_ADDR_W-1:0] addr_q;
  logic [15:0]            wdata_q;
  logic                   cpuRst_q;
  logic                   done_q;
  logic                   error_q;

  logic       accept;
  logic       isHeader;
  logic       accClear;
  logic       accEn;
  logic [7:0] accValue;
  logic [15:0] frameCount;

  assign ByteReady  = !Rst && (state_q != WRITE);
  assign accept     = ByteValid && ByteReady;
  assign isHeader   = (ByteData == HDR_BYTE);
  assign frameCount = {hiByte_q, ByteData};
  assign accClear   = accept && isHeader &&
                      (state_q == IDLE || state_q == RUN || state_q == ERR);
  assign accEn      = accept &&
                      (state_q == CNT_HI || state_q == CNT_LO ||
                       state_q == DATA_HI || state_q == DATA_LO);

  loader_xor_acc u_xorAcc (
    .clk_i   (Clk),
    .rst_i   (Rst),
    .clear_i (accClear),
    .en_i    (accEn),
    .data_i  (ByteData),
    .acc_o   (accValue)
  );

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q  <= IDLE;
      hiByte_q <= '0;
      count_q  <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      cpuRst_q <= 1'b1;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE, RUN, ERR: begin
          if (accept && isHeader) begin
            state_q  <= CNT_HI;
            count_q  <= '0;
            addr_q   <= '0;
            cpuRst_q <= 1'b1;
            done_q   <= 1'b0;
            error_q  <= 1'b0;
          end
        end
        CNT_HI: begin
          if (accept) begin
            hiByte_q <= ByteData;
            state_q  <= CNT_LO;
          end
        end
        CNT_LO: begin
          if (accept) begin
            if (frameCount > MAX_COUNT) begin
              state_q <= ERR;
              error_q <= 1'b1;
            end else if (frameCount == '0) begin
              state_q <= CHECK;
            end else begin
              count_q <= frameCount[COUNT_W-1:0];
              state_q <= DATA_HI;
            end
          end
        end
        DATA_HI: begin
          if (accept) begin
            hiByte_q <= ByteData;
            state_q  <= DATA_LO;
          end
        end
        DATA_LO: begin
          if (accept) begin
            wdata_q <= {hiByte_q, ByteData};
            state_q <= WRITE;
          end
        end
        // Single strobe cycle; the source is stalled so no byte can slip past.
        WRITE: begin
          addr_q  <= addr_q + IMEM_ADDR_W'(1);
          count_q <= count_q - COUNT_W'(1);
          state_q <= (count_q == COUNT_W'(1)) ? CHECK : DATA_HI;
        end
        CHECK: begin
          if (accept) begin
            if (ByteData == accValue) begin
              state_q  <= RUN;
              cpuRst_q <= 1'b0;
              done_q   <= 1'b1;
            end else begin
              state_q  <= ERR;
              cpuRst_q <= 1'b1;
              error_q  <= 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign MemWriteEn   = (state_q == WRITE);
  assign MemAddr      = addr_q;
  assign MemWriteData = wdata_q;
  assign CpuRst       = cpuRst_q;
  assign Done         = done_q;
  assign Error        = error_q;

endmodule

// File: tb/tb_instr_loader.sv
// Randomized frame-level bench for instr_loader: expected writes and status
// come from frame contents, compared against observed write strobes.
module tb_instr_loader;

  logic        Clk = 1'b0;
  logic        Rst;
  logic        ByteValid;
  logic [7:0]  ByteData;
  logic        ByteReady;
  logic        MemWriteEn;
  logic [11:0] MemAddr;
  logic [15:0] MemWriteData;
  logic        CpuRst;
  logic        Done;
  logic        Error;

  int checks = 0;
  int errors = 0;

  logic [27:0] seenWrites[$];
  logic [7:0]  txQ[$];
  logic [15:0] expWords[$];

  instr_loader dut (
    .Clk          (Clk),
    .Rst          (Rst),
    .ByteValid    (ByteValid),
    .ByteData     (ByteData),
    .ByteReady    (ByteReady),
    .MemWriteEn   (MemWriteEn),
    .MemAddr      (MemAddr),
    .MemWriteData (MemWriteData),
    .CpuRst       (CpuRst),
    .Done         (Done),
    .Error        (Error)
  );

  always #5 Clk = ~Clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Every write strobe seen is logged; the source must be stalled during it.
  always @(negedge Clk) begin
    if (MemWriteEn === 1'b1) begin
      seenWrites.push_back({MemAddr, MemWriteData});
      checkOutput("readyInWrite", 32'(ByteReady), 32'd0);
    end
  end

  task automatic applyStimulus(input logic [7:0] b, input int gap);
    int tries;
    if (gap > 0) begin
      ByteValid = 1'b0;
      repeat (gap) @(negedge Clk);
    end
    ByteValid = 1'b1;
    ByteData  = b;
    tries     = 0;
    while (ByteReady !== 1'b1 && tries < 20) begin
      @(negedge Clk);
      tries++;
    end
    if (tries >= 20) checkOutput("readyTimeout", 32'd0, 32'd1);
    @(negedge Clk);
  endtask

  // Frame = header, count, words high-first, XOR of everything after header.
  task automatic buildFrame(input bit bad);
    logic [7:0] chk;
    int n;
    n = expWords.size();
    txQ.delete();
    txQ.push_back(8'hA5);
    txQ.push_back(8'(n >> 8));
    txQ.push_back(8'(n & 255));
    foreach (expWords[i]) begin
      txQ.push_back(expWords[i][15:8]);
      txQ.push_back(expWords[i][7:0]);
    end
    chk = 8'h00;
    for (int i = 1; i < txQ.size(); i++) chk = chk ^ txQ[i];
    if (bad) chk = chk ^ 8'($urandom_range(1, 255));
    txQ.push_back(chk);
  endtask

  task automatic sendTx(input int fromIdx, input int maxGap);
    for (int i = fromIdx; i < txQ.size(); i++)
      applyStimulus(txQ[i], int'($urandom_range(0, maxGap)));
    ByteValid = 1'b0;
  endtask

  task automatic checkFrame(input string tag, input bit good);
    checkOutput({tag, ".nWrites"}, 32'(seenWrites.size()), 32'(expWords.size()));
    foreach (expWords[i]) begin
      if (i < seenWrites.size())
        checkOutput({tag, ".write"}, 32'(seenWrites[i]), 32'({12'(i), expWords[i]}));
    end
    checkOutput({tag, ".Done"},   32'(Done),   32'(good));
    checkOutput({tag, ".Error"},  32'(Error),  32'(!good));
    checkOutput({tag, ".CpuRst"}, 32'(CpuRst), 32'(!good));
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, ".CpuRst"},  32'(CpuRst),       32'd1);
    checkOutput({tag, ".WrEn"},    32'(MemWriteEn),   32'd0);
    checkOutput({tag, ".Addr"},    32'(MemAddr),      32'd0);
    checkOutput({tag, ".WrData"},  32'(MemWriteData), 32'd0);
    checkOutput({tag, ".Done"},    32'(Done),         32'd0);
    checkOutput({tag, ".Error"},   32'(Error),        32'd0);
    checkOutput({tag, ".ReadyRst"}, 32'(ByteReady),   32'd0);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL globalTimeout observed=running expected=finished");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    logic [7:0] junk;
    bit         bad;
    Rst       = 1'b1;
    ByteValid = 1'b0;
    ByteData  = 8'h00;
    repeat (2) @(negedge Clk);
    checkResetOutputs("reset");
    Rst = 1'b0;
    @(negedge Clk);
    checkOutput("readyIdle", 32'(ByteReady), 32'd1);

    seenWrites.delete();
    expWords = '{16'h1234, 16'hABCD};
    buildFrame(1'b0);
    sendTx(0, 3);
    checkFrame("good", 1'b1);

    seenWrites.delete();
    buildFrame(1'b0);
    txQ[txQ.size() - 1] = 8'h43;
    sendTx(0, 2);
    checkFrame("badChk", 1'b0);

    seenWrites.delete();
    expWords.delete();
    txQ = '{8'hA5, 8'h10, 8'h01};
    sendTx(0, 1);
    checkFrame("count4097", 1'b0);

    seenWrites.delete();
    txQ = '{8'hA5, 8'h00, 8'h00, 8'h00};
    sendTx(0, 1);
    checkFrame("count0", 1'b1);

    seenWrites.delete();
    expWords = '{16'h1234, 16'hABCD};
    buildFrame(1'b0);
    sendTx(0, 0);
    checkFrame("continuous", 1'b1);

    seenWrites.delete();
    buildFrame(1'b0);
    for (int i = 0; i < 4; i++) applyStimulus(txQ[i], 0);
    ByteValid = 1'b0;
    Rst = 1'b1;
    @(negedge Clk);
    checkResetOutputs("midReset");
    checkOutput("midReset.nWrites", 32'(seenWrites.size()), 32'd0);
    Rst = 1'b0;
    @(negedge Clk);
    sendTx(0, 2);
    checkFrame("afterReset", 1'b1);

    seenWrites.delete();
    expWords = '{16'(($urandom)), 16'(($urandom)), 16'(($urandom))};
    buildFrame(1'b0);
    applyStimulus(txQ[0], 0);
    checkOutput("reload.CpuRst", 32'(CpuRst), 32'd1);
    checkOutput("reload.Done",   32'(Done),   32'd0);
    sendTx(1, 2);
    checkFrame("reload", 1'b1);

    for (int f = 0; f < 10; f++) begin
      seenWrites.delete();
      expWords.delete();
      for (int w = 0; w < int'($urandom_range(0, 6)); w++)
        expWords.push_back(16'($urandom));
      bad = ($urandom_range(0, 3) == 0);
      buildFrame(bad);
      for (int j = 0; j < int'($urandom_range(0, 2)); j++) begin
        junk = 8'($urandom_range(0, 255));
        if (junk == 8'hA5) junk = 8'h00;
        applyStimulus(junk, 1);
      end
      sendTx(0, 2);
      checkFrame("random", !bad);
    end

    repeat (3) @(negedge Clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
